reg_dump_tx: RTL
================

Name: reg_dump_tx

Overview:
- Read-side debug companion to the CPU register file, for on-board bring-up.
- On a start pulse it walks register indices 0..NUM_REGS-1 through one asynchronous register-file read port.
- It snapshots each 32-bit value and serialises it on a UART TX line (8N1) to a host terminal.
- Sits beside the single-cycle core and shares the register file's combinational read path. It never writes.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
- NUM_REGS, 32, number of registers dumped, starting at index 0; legal range 1..32

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a dump; sampled only in IDLE
- rd_addr  output  5  register index driven to the register-file read port
- rd_data  input  32  combinational read data for rd_addr
- txd  output  1  UART serial out; idle level 1
- busy  output  1  high from the cycle after start is accepted until the done pulse, inclusive
- done  output  1  single-cycle pulse after the last stop bit

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: txd=1, busy=0, done=0, rd_addr=0, index=0, byte count=0, bit count=0, baud counter=0, state=IDLE.
- All outputs are registered.
- State machine: IDLE -> FETCH -> LATCH -> START -> DATA -> STOP -> (NEXT_BYTE | NEXT_REG | FINISH) -> IDLE.
- IDLE:
  - txd=1 and busy=0.
  - start=1 -> FETCH with index=0.
  - start while busy is ignored; no queuing.
- FETCH, 1 cycle:
  - rd_addr=index.
- LATCH, 1 cycle:
  - word <= rd_data, a 32-bit snapshot.
  - Later changes to that register do not affect bytes already in flight.
- Byte order is big-endian: word[31:24] first, word[7:0] last.
- Bit order within a byte is LSB first.
- START:
  - txd=0 for CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, each held for exactly CLKS_PER_BIT cycles.
- STOP:
  - txd=1 for CLKS_PER_BIT cycles.
- After STOP:
  - If bytes remain for this register -> START of the next byte directly, with no extra idle cycle.
  - Else, if index < NUM_REGS-1 -> index+1, then FETCH.
  - Else -> FINISH.
- FINISH, 1 cycle:
  - done=1, busy still 1.
  - Next cycle: IDLE, busy=0, done=0.
- Latency:
  - start is high at edge t. FETCH occupies cycle t+1 and LATCH occupies t+2.
  - txd falls for the first start bit in cycle t+3.
- Per-register cost is 2 + 4*10*CLKS_PER_BIT cycles.
- Between registers txd stays 1 for the 2 FETCH/LATCH cycles.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps. The bit and byte counters wrap to 0 at their terminal counts.
- index never exceeds NUM_REGS-1, so rd_addr stays legal.
- Reset asserted mid-frame:
  - txd returns to 1 immediately (asynchronously) and all state clears.
  - No done pulse is produced.
  - A truncated frame on the line is acceptable.
- start held high continuously produces back-to-back dumps. A new dump begins one cycle after FINISH, since IDLE samples start.
- rd_addr holds its last value outside FETCH.

Optional Feature:
- Macro: REG_DUMP_HDR_EN.
- Defined:
  - Each register is preceded by one header byte, 8'h80 | index (e.g. r5 -> 8'h85).
  - Five bytes per register.
  - Per-register cost becomes 2 + 5*10*CLKS_PER_BIT cycles.
  - The header byte is sent before word[31:24].
- Undefined:
  - Four data bytes per register only.
  - No header logic is synthesised.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4 -> txd=1, busy=0, done=0, rd_addr=0. No transitions for 100 cycles without start.
- Model regs r[i]=32'h01020300+i, NUM_REGS=32, start pulse -> 128 bytes decoded, starting 01 02 03 00 01 02 03 01. done pulses exactly once, at cycle t + 32*(2+160)+1.
- Single register, NUM_REGS=1, r0=32'hA5C3_0F81 -> bytes A5 C3 0F 81. Each bit is 4 cycles and txd falls at t+3.
- Model changes r1 in the middle of transmitting r1's second byte -> the old r1 value is sent intact; the new value appears only on the next dump.
- Assert rst during DATA of byte 2 of r3 -> txd=1 within the same cycle. busy=0, no done, rd_addr=0. A following start restarts at r0.
- With REG_DUMP_HDR_EN defined, NUM_REGS=2, r1=32'hDEADBEEF -> byte stream 80 00 00 00 00 81 DE AD BE EF; done at t + 2*(2+200)+1.

Source files
------------

// File: rtl/reg_dump_tx.sv
// Register-file dump over UART 8N1: walks indices 0..NUM_REGS-1 and sends each word big-endian,
// LSB-first bits. Define REG_DUMP_HDR_EN to prefix every register with header byte 8'h80 | index.
module reg_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef REG_DUMP_HDR_EN
  localparam int unsigned NumBytes = 5;
`else
  localparam int unsigned NumBytes = 4;
`endif
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       ByteLast = 3'(NumBytes - 1);
  localparam logic [4:0]       IdxLast  = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StStart,
    StData,
    StStop,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       word_q, word_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              baud_tick;
  logic [BaudW-1:0]  baud_next;
  logic [7:0]        cur_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      word_q    <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      word_q    <= word_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    baud_tick = (baud_q == BaudLast);
    baud_next = baud_tick ? '0 : baud_q + BaudW'(1);
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    word_d    = word_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StFetch;
          idx_d     = '0;
          rd_addr_d = '0;
          baud_d    = '0;
          bit_d     = '0;
          byte_d    = '0;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        // Snapshot taken once per register; later writes cannot corrupt bytes in flight.
        word_d  = rd_data;
        baud_d  = '0;
        state_d = StStart;
      end
      StStart: begin
        baud_d = baud_next;
        if (baud_tick) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        baud_d = baud_next;
        if (baud_tick) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        baud_d = baud_next;
        if (baud_tick) begin
          if (byte_q != ByteLast) begin
            byte_d  = byte_q + 3'd1;
            state_d = StStart;
          end else begin
            byte_d = '0;
            if (idx_q != IdxLast) begin
              idx_d     = idx_q + 5'd1;
              rd_addr_d = idx_q + 5'd1;
              state_d   = StFetch;
            end else begin
              state_d = StFinish;
            end
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state values so the registered copies align with the state.
  always_comb begin
    case (byte_d)
`ifdef REG_DUMP_HDR_EN
      3'd0:    cur_byte = {3'b100, idx_q};
      3'd1:    cur_byte = word_q[31:24];
      3'd2:    cur_byte = word_q[23:16];
      3'd3:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
`else
      3'd0:    cur_byte = word_q[31:24];
      3'd1:    cur_byte = word_q[23:16];
      3'd2:    cur_byte = word_q[15:8];
      default: cur_byte = word_q[7:0];
`endif
    endcase
    txd_d = 1'b1;
    if (state_d == StStart) begin
      txd_d = 1'b0;
    end else if (state_d == StData) begin
      txd_d = cur_byte[bit_d];
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StFinish);
  end

  assign rd_addr = rd_addr_q;
  assign txd     = txd_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
